// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared types and constants for the IDCT transpose buffer
package jpeg_pkg;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bank_state_t;

    // Bit p is set when beat phase p presents the even rows 0,2,4,6
    localparam logic [7:0] EVEN_PHASES = 8'b1110_0101;

    localparam int OUT_W_DEFAULT = 16;

    function automatic longint sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/jpeg_idct_tbuf_bank.sv
// jpeg_idct_tbuf_bank: one 64-entry transpose bank, one write port, four column read lanes
module jpeg_idct_tbuf_bank #(
    parameter int W = 16
) (
    input  logic                clk_i,
    input  logic                wr_en_i,
    input  logic [5:0]          wr_idx_i,
    input  logic [W-1:0]        wr_data_i,
    input  logic [2:0]          rd_col_i,
    input  logic                rd_odd_i,
    output logic [3:0][W-1:0]   rd_data_o
);

    logic [W-1:0] mem [64];

    // Storage is deliberately left out of reset; only the bank state gates its use
    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem[wr_idx_i] <= wr_data_i;
    end

    // Lane g reads row 2g (+1 on odd phases) of the selected column
    for (genvar g = 0; g < 4; g++) begin : g_rd
        assign rd_data_o[g] = mem[{2'(g), rd_odd_i, rd_col_i}];
    end

endmodule

// File: rtl/jpeg_idct_transpose.sv
// jpeg_idct_transpose: ping-pong transpose buffer between row and column IDCT stages
module jpeg_idct_transpose
    import jpeg_pkg::*;
#(
    parameter int DATA_IN_W  = 21,
    parameter int DATA_OUT_W = OUT_W_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  img_start_i,
    input  logic                  img_end_i,
    input  logic                  inport_valid_i,
    input  logic [DATA_IN_W-1:0]  inport_data_i,
    input  logic [5:0]            inport_idx_i,
    output logic                  inport_accept_o,
    output logic                  outport_valid_o,
    output logic [DATA_OUT_W-1:0] outport_data0_o,
    output logic [DATA_OUT_W-1:0] outport_data1_o,
    output logic [DATA_OUT_W-1:0] outport_data2_o,
    output logic [DATA_OUT_W-1:0] outport_data3_o,
    output logic [2:0]            outport_idx_o,
    output logic [2:0]            outport_col_o,
    input  logic                  outport_accept_i,
    output logic                  overflow_o
);

    localparam logic signed [DATA_IN_W-1:0] IN_MAX  = DATA_IN_W'(sat_max(DATA_OUT_W));
    localparam logic signed [DATA_IN_W-1:0] IN_MIN  = DATA_IN_W'(sat_min(DATA_OUT_W));
    localparam logic [DATA_OUT_W-1:0]       OUT_MAX = DATA_OUT_W'(sat_max(DATA_OUT_W));
    localparam logic [DATA_OUT_W-1:0]       OUT_MIN = DATA_OUT_W'(sat_min(DATA_OUT_W));

    bank_state_t [1:0]               state_q, state_d;
    logic                            wr_ptr, rd_ptr, rd_next;
    logic [2:0]                      beat_q, col_q, nxt_beat, nxt_col;
    logic                            wr_en, adv, last, start, nxt_bank, rd_odd;
    logic signed [DATA_IN_W-1:0]     din;
    logic [DATA_OUT_W-1:0]           din_sat;
    logic [1:0][3:0][DATA_OUT_W-1:0] rd_data;
    logic [3:0][DATA_OUT_W-1:0]      lanes_q;
    logic                            unused_img_end;

    assign unused_img_end = img_end_i;

    assign din     = inport_data_i;
    assign din_sat = (din > IN_MAX) ? OUT_MAX : (din < IN_MIN) ? OUT_MIN : din[DATA_OUT_W-1:0];

    assign inport_accept_o = (state_q[wr_ptr] == BANK_EMPTY) || (state_q[wr_ptr] == BANK_FILLING);
    assign wr_en           = inport_valid_i && inport_accept_o && !img_start_i;

    // A drain finishes on the accepted c=7,p=7 beat; the next FULL bank starts in the same cycle
    assign adv     = outport_valid_o && outport_accept_i;
    assign last    = adv && (beat_q == 3'd7) && (col_q == 3'd7);
    assign rd_next = rd_ptr ^ last;
    assign start   = (!outport_valid_o || last) && (state_q[rd_next] == BANK_FULL);

    assign nxt_beat = start ? 3'd0 : adv ? beat_q + 3'd1 : beat_q;
    assign nxt_col  = start ? 3'd0 : (adv && beat_q == 3'd7) ? col_q + 3'd1 : col_q;
    assign nxt_bank = start ? rd_next : rd_ptr;
    assign rd_odd   = !EVEN_PHASES[nxt_beat];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        jpeg_idct_tbuf_bank #(.W(DATA_OUT_W)) u_bank (
            .clk_i     (clk_i),
            .wr_en_i   (wr_en && (wr_ptr == 1'(b))),
            .wr_idx_i  (inport_idx_i),
            .wr_data_i (din_sat),
            .rd_col_i  (nxt_col),
            .rd_odd_i  (rd_odd),
            .rd_data_o (rd_data[b])
        );
    end

    // Per-bank next state: write fills, final accept empties, drain start claims a FULL bank
    always_comb begin
        state_d = state_q;
        for (int i = 0; i < 2; i++) begin
            if (wr_en && wr_ptr == i[0]) state_d[i] = (inport_idx_i == 6'd63) ? BANK_FULL : BANK_FILLING;
            if (last && rd_ptr == i[0]) state_d[i] = BANK_EMPTY;
            if (start && rd_next == i[0]) state_d[i] = BANK_DRAINING;
        end
    end

    // Bank states, pointers and the registered column beat
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q[0]      <= BANK_EMPTY;
            state_q[1]      <= BANK_EMPTY;
            wr_ptr          <= 1'b0;
            rd_ptr          <= 1'b0;
            beat_q          <= 3'd0;
            col_q           <= 3'd0;
            outport_valid_o <= 1'b0;
            overflow_o      <= 1'b0;
            lanes_q         <= '0;
        end else if (img_start_i) begin
            state_q[0]      <= BANK_EMPTY;
            state_q[1]      <= BANK_EMPTY;
            wr_ptr          <= 1'b0;
            rd_ptr          <= 1'b0;
            beat_q          <= 3'd0;
            col_q           <= 3'd0;
            outport_valid_o <= 1'b0;
            overflow_o      <= 1'b0;
        end else begin
            state_q         <= state_d;
            rd_ptr          <= rd_next;
            beat_q          <= nxt_beat;
            col_q           <= nxt_col;
            outport_valid_o <= start || (outport_valid_o && !last);
            if (inport_valid_i && !inport_accept_o) overflow_o <= 1'b1;
            if (wr_en && inport_idx_i == 6'd63) wr_ptr <= ~wr_ptr;
            if (start || adv) lanes_q <= rd_data[nxt_bank];
        end
    end

    assign outport_idx_o   = beat_q;
    assign outport_col_o   = col_q;
    assign outport_data0_o = lanes_q[0];
    assign outport_data1_o = lanes_q[1];
    assign outport_data2_o = lanes_q[2];
    assign outport_data3_o = lanes_q[3];

endmodule

// File: tb/tb_jpeg_idct_transpose.sv
// tb_jpeg_idct_transpose: randomized self-checking bench for the IDCT transpose buffer
module tb_jpeg_idct_transpose;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b1;
    logic        img_start_i = 1'b0;
    logic        img_end_i = 1'b0;
    logic        inport_valid_i = 1'b0;
    logic [20:0] inport_data_i = '0;
    logic [5:0]  inport_idx_i = '0;
    logic        inport_accept_o;
    logic        outport_valid_o;
    logic [15:0] outport_data0_o, outport_data1_o, outport_data2_o, outport_data3_o;
    logic [2:0]  outport_idx_o, outport_col_o;
    logic        outport_accept_i = 1'b0;
    logic        overflow_o;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [2:0]       col;
        logic [2:0]       idx;
        logic [3:0][15:0] lanes;
    } beat_t;

    beat_t got_q[$];
    beat_t exp_q[$];
    int    cur[64];
    int    vals[64];

    jpeg_idct_transpose dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .img_start_i      (img_start_i),
        .img_end_i        (img_end_i),
        .inport_valid_i   (inport_valid_i),
        .inport_data_i    (inport_data_i),
        .inport_idx_i     (inport_idx_i),
        .inport_accept_o  (inport_accept_o),
        .outport_valid_o  (outport_valid_o),
        .outport_data0_o  (outport_data0_o),
        .outport_data1_o  (outport_data1_o),
        .outport_data2_o  (outport_data2_o),
        .outport_data3_o  (outport_data3_o),
        .outport_idx_o    (outport_idx_o),
        .outport_col_o    (outport_col_o),
        .outport_accept_i (outport_accept_i),
        .overflow_o       (overflow_o)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int v);
        return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
    endfunction

    function automatic beat_t dut_beat();
        return {outport_col_o, outport_idx_o, outport_data3_o, outport_data2_o, outport_data1_o, outport_data0_o};
    endfunction

    // Reference transpose: a completed block becomes 8 columns x 8 phases of row pairs
    function automatic void push_block();
        beat_t b;
        int row;
        for (int c = 0; c < 8; c++) begin
            for (int p = 0; p < 8; p++) begin
                b.col = 3'(c);
                b.idx = 3'(p);
                for (int k = 0; k < 4; k++) begin
                    row = (p inside {0, 2, 5, 6, 7}) ? 2 * k : 2 * k + 1;
                    b.lanes[k] = 16'(cur[row * 8 + c]);
                end
                exp_q.push_back(b);
            end
        end
    endfunction

    function automatic void model_write(input int idx, input int v);
        cur[idx] = sat(v);
        if (idx == 63) push_block();
    endfunction

    task automatic tick();
        if (outport_valid_o && outport_accept_i) got_q.push_back(dut_beat());
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int idx, input int v, input bit acc);
        inport_valid_i = 1'b1;
        inport_idx_i   = 6'(idx);
        inport_data_i  = 21'(v);
        if (acc) model_write(idx, v);
        tick();
        inport_valid_i = 1'b0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 64; i++) vals[i] = int'($urandom_range(80000)) - 40000;
    endtask

    task automatic write_block(input bit shuffle);
        int order[64];
        int j, t;
        for (int i = 0; i < 64; i++) order[i] = i;
        if (shuffle) begin
            for (int i = 62; i > 0; i--) begin
                j = int'($urandom_range(i));
                t = order[i];
                order[i] = order[j];
                order[j] = t;
            end
        end
        for (int i = 0; i < 64; i++) wr(order[i], vals[order[i]], 1'b1);
    endtask

    task automatic drain(input int n, output bit ok);
        outport_accept_i = 1'b1;
        for (int i = 0; i < n * 4 + 50 && got_q.size() < n; i++) tick();
        ok = got_q.size() >= n;
    endtask

    task automatic apply_reset();
        inport_valid_i   = 1'b0;
        img_start_i      = 1'b0;
        outport_accept_i = 1'b0;
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        #2 rst_ni = 1'b0;
        #1;
        n_cmp++; if (outport_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", outport_valid_o); end
        n_cmp++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL rst_overflow got %b exp 0", overflow_o); end
        n_cmp++; if (outport_idx_o !== 3'd0 || outport_col_o !== 3'd0) begin n_fail++; $display("FAIL rst_idx_col got %0d/%0d exp 0/0", outport_idx_o, outport_col_o); end
        n_cmp++; if ({outport_data3_o, outport_data2_o, outport_data1_o, outport_data0_o} !== 64'd0) begin n_fail++; $display("FAIL rst_lanes got %h exp 0", {outport_data3_o, outport_data2_o, outport_data1_o, outport_data0_o}); end
        n_cmp++; if (inport_accept_o !== 1'b1) begin n_fail++; $display("FAIL rst_accept got %b exp 1", inport_accept_o); end
        tick();
        rst_ni = 1'b1;
        tick();
        n_cmp++; if (outport_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_idle_valid got %b exp 0", outport_valid_o); end
    endtask

    task automatic test_basic();
        bit ok;
        apply_reset();
        outport_accept_i = 1'b1;
        for (int i = 0; i < 64; i++) vals[i] = i;
        write_block(1'b0);
        n_cmp++; if (outport_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_lat0 got %b exp 0", outport_valid_o); end
        tick();
        n_cmp++; if (outport_valid_o !== 1'b1) begin n_fail++; $display("FAIL basic_lat1 got %b exp 1", outport_valid_o); end
        drain(64, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL basic_timeout got %0d beats exp 64", got_q.size()); end
        repeat (10) tick();
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        if (got_q.size() > 25) begin
            n_cmp++; if (got_q[24].lanes !== {16'd51, 16'd35, 16'd19, 16'd3}) begin n_fail++; $display("FAIL basic_c3p0 got %h exp 51,35,19,3", got_q[24].lanes); end
            n_cmp++; if (got_q[25].lanes !== {16'd59, 16'd43, 16'd27, 16'd11}) begin n_fail++; $display("FAIL basic_c3p1 got %h exp 59,43,27,11", got_q[25].lanes); end
        end
        n_cmp++; if (outport_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_idle got %b exp 0", outport_valid_o); end
    endtask

    task automatic test_saturation();
        bit ok;
        apply_reset();
        outport_accept_i = 1'b1;
        fill_random();
        vals[0] = 40000;
        vals[1] = -40000;
        write_block(1'b1);
        drain(64, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL sat_timeout got %0d beats exp 64", got_q.size()); end
        repeat (10) tick();
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL sat_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL sat_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        if (got_q.size() > 8) begin
            n_cmp++; if (got_q[0].lanes[0] !== 16'h7fff) begin n_fail++; $display("FAIL sat_pos got %h exp 7fff", got_q[0].lanes[0]); end
            n_cmp++; if (got_q[8].lanes[0] !== 16'h8000) begin n_fail++; $display("FAIL sat_neg got %h exp 8000", got_q[8].lanes[0]); end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        apply_reset();
        for (int w = 0; w < 192; w++) begin
            if (w == 127) begin
                n_cmp++; if (inport_accept_o !== 1'b1) begin n_fail++; $display("FAIL ovf_accept_before got %b exp 1", inport_accept_o); end
            end
            wr(w % 64, int'($urandom_range(80000)) - 40000, w < 128);
            if (w == 127) begin
                n_cmp++; if (inport_accept_o !== 1'b0) begin n_fail++; $display("FAIL ovf_accept_after got %b exp 0", inport_accept_o); end
                n_cmp++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b exp 0", overflow_o); end
            end
            if (w == 128) begin
                n_cmp++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b exp 1", overflow_o); end
            end
        end
        drain(128, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL ovf_timeout got %0d beats exp 128", got_q.size()); end
        repeat (10) tick();
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ovf_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", overflow_o); end
        n_cmp++; if (inport_accept_o !== 1'b1) begin n_fail++; $display("FAIL ovf_accept_free got %b exp 1", inport_accept_o); end
    endtask

    task automatic test_back_to_back();
        bit    hold;
        beat_t saved;
        apply_reset();
        fill_random();
        write_block(1'b1);
        fill_random();
        write_block(1'b1);
        hold = 1'b0;
        saved = '0;
        for (int i = 0; i < 600 && got_q.size() < 128; i++) begin
            n_cmp++; if (outport_valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_bubble got %b exp 1 at beat %0d", outport_valid_o, got_q.size()); end
            if (hold) begin
                n_cmp++; if (dut_beat() !== saved) begin n_fail++; $display("FAIL b2b_hold got %h exp %h", dut_beat(), saved); end
            end
            outport_accept_i = i[0];
            hold = outport_valid_o && !outport_accept_i;
            saved = dut_beat();
            tick();
        end
        outport_accept_i = 1'b1;
        repeat (10) tick();
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        apply_reset();
        fill_random();
        write_block(1'b1);
        fill_random();
        for (int i = 0; i < 30; i++) wr(i, vals[i], 1'b0);
        rst_ni = 1'b0;
        #1;
        n_cmp++; if (outport_valid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b exp 0", outport_valid_o); end
        tick();
        rst_ni = 1'b1;
        tick();
        got_q.delete();
        exp_q.delete();
        n_cmp++; if (inport_accept_o !== 1'b1) begin n_fail++; $display("FAIL rmid_accept got %b exp 1", inport_accept_o); end
        outport_accept_i = 1'b1;
        fill_random();
        write_block(1'b1);
        drain(64, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL rmid_timeout got %0d beats exp 64", got_q.size()); end
        repeat (10) tick();
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rmid_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rmid_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_img_start();
        bit ok;
        apply_reset();
        for (int w = 0; w < 129; w++) wr(w % 64, int'($urandom_range(80000)) - 40000, w < 128);
        n_cmp++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL img_ovf_pre got %b exp 1", overflow_o); end
        outport_accept_i = 1'b1;
        for (int i = 0; i < 200 && outport_col_o != 3'd4; i++) tick();
        n_cmp++; if (outport_col_o !== 3'd4 || outport_valid_o !== 1'b1) begin n_fail++; $display("FAIL img_reach_c4 got col %0d valid %b exp col 4 valid 1", outport_col_o, outport_valid_o); end
        img_start_i = 1'b1;
        tick();
        img_start_i = 1'b0;
        n_cmp++; if (outport_valid_o !== 1'b0) begin n_fail++; $display("FAIL img_valid got %b exp 0", outport_valid_o); end
        n_cmp++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL img_ovf_clr got %b exp 0", overflow_o); end
        n_cmp++; if (outport_idx_o !== 3'd0 || outport_col_o !== 3'd0) begin n_fail++; $display("FAIL img_counters got %0d/%0d exp 0/0", outport_idx_o, outport_col_o); end
        n_cmp++; if (inport_accept_o !== 1'b1) begin n_fail++; $display("FAIL img_accept got %b exp 1", inport_accept_o); end
        got_q.delete();
        exp_q.delete();
        fill_random();
        write_block(1'b1);
        drain(64, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL img_timeout got %0d beats exp 64", got_q.size()); end
        repeat (10) tick();
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL img_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL img_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_img_start();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/jpeg_idct_transpose.md
JPEG_IDCT_TRANSPOSE -- requirements
Module: jpeg_idct_transpose

Interface
REQ-001 SHALL have parameter DATA_IN_W, default 21, meaning the width of signed row-IDCT result samples.
REQ-002 SHALL have parameter DATA_OUT_W, default 16, meaning the width of signed column-stage lanes.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port img_start_i, input, 1 bit: image start, a synchronous flush.
REQ-006 SHALL have port img_end_i, input, 1 bit: image end, informational only and without effect.
REQ-007 SHALL have port inport_valid_i, input, 1 bit: a row-stage sample is present.
REQ-008 SHALL have port inport_data_i, input, DATA_IN_W bits: the signed sample.
REQ-009 SHALL have port inport_idx_i, input, 6 bits: the sample position, row*8+col, row-major.
REQ-010 SHALL have port inport_accept_o, output, 1 bit: the write bank can take a sample.
REQ-011 SHALL have port outport_valid_o, output, 1 bit: a column beat is presented.
REQ-012 SHALL have ports outport_data0_o..outport_data3_o, output, DATA_OUT_W bits each: the four column lanes.
REQ-013 SHALL have port outport_idx_o, output, 3 bits: the beat phase 0..7 within a column.
REQ-014 SHALL have port outport_col_o, output, 3 bits: the column 0..7 being presented.
REQ-015 SHALL have port outport_accept_i, input, 1 bit: the downstream takes the current beat.
REQ-016 SHALL have port overflow_o, output, 1 bit: sticky flag, set when a sample arrived with no bank free.

Function
REQ-017 SHALL hold two 64-entry banks, ping-pong; each bank has a state EMPTY, FILLING, FULL or DRAINING.
REQ-018 SHALL write a sample when inport_valid_i && inport_accept_o, into entry inport_idx_i of the write bank; an EMPTY bank becomes FILLING.
REQ-019 SHALL saturate each sample to [-32768, 32767] before storing it.
REQ-020 SHALL move the write bank to FULL, and toggle the write-bank pointer, when entry 63 is written; samples may arrive in any order, and idx 63 alone marks the block as complete.
REQ-021 SHALL drive inport_accept_o = (write-bank state is EMPTY or FILLING), combinationally from state.
REQ-022 SHALL discard any sample that arrives with valid high and accept low, and set overflow_o.
REQ-023 SHALL start the read bank DRAINING the cycle after it becomes FULL, and raise outport_valid_o on that same cycle (1-cycle latency from the last write).
REQ-024 SHALL present each column c as 8 beats, p = 0..7, with outport_idx_o = p and outport_col_o = c.
REQ-025 SHALL, on phases p in {0,2,5,6,7}, drive lanes 0..3 with rows 0,2,4,6 of column c.
REQ-026 SHALL, on phases p in {1,3,4}, drive lanes 0..3 with rows 1,3,5,7 of column c.
REQ-027 SHALL register all outport_* signals and hold them stable while outport_valid_o && !outport_accept_i.
REQ-028 SHALL advance the beat on accept; after p=7 it SHALL move to the next column at p=0.
REQ-029 SHALL, when the beat c=7, p=7 is accepted, return the bank to EMPTY and toggle the read pointer.
REQ-030 SHALL, in that same cycle, begin the other bank (p=0, c=0) with no bubble if it is FULL; otherwise outport_valid_o SHALL drop.
REQ-031 SHALL allow a write to one bank and the final accept on the other bank in the same cycle; both take effect.
REQ-032 SHALL, on img_start_i, set both banks to EMPTY, both pointers to 0, the beat and column counters to 0, outport_valid_o to 0 and overflow_o to 0; any write in that cycle SHALL be ignored.

Reset
REQ-033 SHALL, while rst_ni is low, asynchronously set: both bank states EMPTY, pointers 0, counters 0, outport_valid_o 0, overflow_o 0, outport_idx_o 0, outport_col_o 0 and all data lanes 0.
REQ-034 SHALL NOT reset bank storage contents.
REQ-035 SHALL, on reset assertion mid-block, abandon partial and queued blocks; no beat SHALL be emitted until 64 new writes complete a bank.

Structure
REQ-036 SHALL place the bank-state enum, DATA_OUT_W saturation limits and the even-phase set {0,2,5,6,7} in the shared package jpeg_pkg.
REQ-037 SHALL instantiate one sub-module per bank, jpeg_idct_tbuf_bank: 64 x DATA_OUT_W storage, 1 write port, 4 read ports selected by (column, even/odd).

Verification
REQ-038 SHALL cover: write 64 samples, value = idx, with accept tied high -> 64 beats; column 3, p=0 gives 3,19,35,51; p=1 gives 11,27,43,59; valid rises 1 cycle after the idx-63 write.
REQ-039 SHALL cover: inputs +40000 and -40000 -> lanes read 32767 and -32768.
REQ-040 SHALL cover: three back-to-back blocks with accept low -> inport_accept_o falls after the 128th write; the 129th sample is dropped and overflow_o=1.
REQ-041 SHALL cover: two full banks, accept pulsed every other cycle -> output held stable between accepts, no bubble at the bank switch, 128 beats total.
REQ-042 SHALL cover: rst_ni low after 30 writes, then 64 new writes -> output matches only the new block.
REQ-043 SHALL cover: img_start_i during drain at c=4 -> valid=0 next cycle; overflow_o cleared; a new block drains from c=0, p=0.
